// File: rtl/nn_pkg.sv
// nn_pkg: shared sign-magnitude types, widths, FSM states and zero-sign normaliser
package nn_pkg;
  localparam int ACC_W = 21;
  localparam int MAG_W = ACC_W - 1;
  typedef struct packed {
    logic             sign;
    logic [MAG_W-1:0] mag;
  } sm_t;
  typedef enum logic [1:0] {ACC, DRAIN, OUT} state_t;
  function automatic sm_t sm_norm(input sm_t v);
    sm_norm = v;
    if (v.mag == '0) sm_norm.sign = 1'b0;
  endfunction
endpackage

// File: rtl/sm_accum_add.sv
// sm_accum_add: combinational sign-magnitude add with overflow flag; SATURATE_EN clamps instead of wrapping
module sm_accum_add
  import nn_pkg::*;
(
  input  sm_t  i_a,
  input  sm_t  i_b,
  output sm_t  o_y,
  output logic o_ovf
);
  logic [MAG_W:0]   w_sum;
  logic [MAG_W-1:0] w_diff;
  logic [MAG_W-1:0] w_mag;
  logic             w_same;
  logic             w_a_ge;
  assign w_same = i_a.sign == i_b.sign;
  assign w_sum  = {1'b0, i_a.mag} + {1'b0, i_b.mag};
  assign w_a_ge = i_a.mag >= i_b.mag;
  assign w_diff = w_a_ge ? i_a.mag - i_b.mag : i_b.mag - i_a.mag;
  assign o_ovf  = w_same & w_sum[MAG_W];
`ifdef SATURATE_EN
  assign w_mag  = o_ovf ? '1 : w_sum[MAG_W-1:0];
`else
  assign w_mag  = w_sum[MAG_W-1:0];
`endif
  assign o_y = sm_norm(w_same ? {i_a.sign, w_mag} : {(w_a_ge ? i_a.sign : i_b.sign), w_diff});
endmodule

// File: rtl/neuron_mac_accumulator.sv
// neuron_mac_accumulator: streaming sign-magnitude MAC onto a bias with valid/ready result; SATURATE_EN selects clamping
module neuron_mac_accumulator #(
  parameter int X_W       = 9,
  parameter int W_W       = 9,
  parameter int ACC_W     = 21,
  parameter int MAX_TERMS = 16,
  localparam int CNT_W    = $clog2(MAX_TERMS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   in_x,
  input  logic [W_W-1:0]   in_w,
  input  logic             in_last,
  input  logic [ACC_W-1:0] bias,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf,
  output logic             out_err
);
  import nn_pkg::*;
  state_t                 r_state, w_next;
  sm_t                    r_acc, r_prod, w_sum;
  logic                   r_prod_vld, r_ovf, r_err;
  logic [CNT_W-1:0]       r_cnt;
  logic                   w_fire, w_done, w_max, w_ovf;
  logic [X_W+W_W-3:0]     w_pmag;
  assign in_ready  = r_state == ACC;
  assign out_valid = r_state == OUT;
  assign w_fire    = in_valid & in_ready;
  assign w_done    = out_valid & out_ready;
  assign w_max     = r_cnt == CNT_W'(MAX_TERMS - 1);
  assign w_pmag    = in_x[X_W-2:0] * in_w[W_W-2:0];
  assign out_sum   = r_acc;
  assign out_count = r_cnt;
  assign out_ovf   = r_ovf;
  assign out_err   = r_err;
  sm_accum_add u_add (
    .i_a   (r_acc),
    .i_b   (r_prod),
    .o_y   (w_sum),
    .o_ovf (w_ovf)
  );
  // next state: close the neuron on last/max beat, drain one cycle, hold until consumed
  always_comb begin
    w_next = r_state;
    if (r_state == ACC && w_fire && (in_last || w_max)) w_next = DRAIN;
    else if (r_state == DRAIN) w_next = OUT;
    else if (w_done) w_next = ACC;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACC;
    else r_state <= w_next;
  end
  // product stage, then accumulate stage; the first beat seeds the accumulator with bias
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_ovf      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_prod_vld <= w_fire;
      if (w_fire) r_prod <= sm_norm({in_x[X_W-1] ^ in_w[W_W-1], MAG_W'(w_pmag)});
      if (w_done) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_ovf <= 1'b0;
        r_err <= 1'b0;
      end else begin
        if (w_fire) r_cnt <= r_cnt + 1'b1;
        if (w_fire && w_max && !in_last) r_err <= 1'b1;
        if (w_fire && r_cnt == '0) r_acc <= sm_norm(sm_t'(bias));
        else if (r_prod_vld) begin
          r_acc <= w_sum;
          r_ovf <= r_ovf | w_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_neuron_mac_accumulator.sv
// tb_neuron_mac_accumulator: directed table-driven check of the neuron MAC accumulator
module tb_neuron_mac_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_x = '0;
  logic [8:0]  in_w = '0;
  logic        in_last = 1'b0;
  logic [20:0] bias = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [20:0] out_sum;
  logic [2:0]  out_count;
  logic        out_ovf;
  logic        out_err;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  neuron_mac_accumulator #(.X_W(9), .W_W(9), .ACC_W(21), .MAX_TERMS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_w      (in_w),
    .in_last   (in_last),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .out_ovf   (out_ovf),
    .out_err   (out_err)
  );

  typedef struct {
    logic [20:0]     bias;
    int              n;
    logic [3:0][8:0] x;
    logic [3:0][8:0] w;
    logic            last;
    logic [20:0]     sum;
    int              cnt;
    logic            ovf;
    logic            err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string nm, input int hold);
    logic [20:0] s;
    out_ready = (hold == 0);
    bias = v.bias;
    for (int i = 0; i < v.n; i++) begin
      in_valid = 1'b1;
      in_x = v.x[i];
      in_w = v.w[i];
      in_last = v.last && (i == v.n - 1);
      chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk({nm, "_drain_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_sum"}, 32'(out_sum), 32'(v.sum));
    chk({nm, "_count"}, 32'(out_count), 32'(v.cnt));
    chk({nm, "_ovf"}, 32'(out_ovf), 32'(v.ovf));
    chk({nm, "_err"}, 32'(out_err), 32'(v.err));
    s = out_sum;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_x = 9'h0ff;
      in_w = 9'h0ff;
      in_last = 1'b1;
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({nm, "_hold_sum"}, 32'(out_sum), 32'(v.sum));
      chk({nm, "_hold_count"}, 32'(out_count), 32'(v.cnt));
      chk({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last = 1'b0;
    chk({nm, "_post_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_post_in_ready"}, 32'(in_ready), 32'd1);
    if (hold > 0) chk({nm, "_held_sum"}, 32'(s), 32'(v.sum));
  endtask

  vec_t tv[8];
  vec_t hv;

  initial begin
    tv[0] = '{21'h000000, 3, {9'h000, 9'h001, 9'h102, 9'h003}, {9'h000, 9'h101, 9'h005, 9'h004},
              1'b1, 21'h000001, 3, 1'b0, 1'b0};
`ifdef SATURATE_EN
    tv[1] = '{21'h0ffff0, 1, {9'h0, 9'h0, 9'h0, 9'h0ff}, {9'h0, 9'h0, 9'h0, 9'h0ff},
              1'b1, 21'h0fffff, 1, 1'b1, 1'b0};
    tv[7] = '{21'h1fffff, 1, {9'h0, 9'h0, 9'h0, 9'h101}, {9'h0, 9'h0, 9'h0, 9'h001},
              1'b1, 21'h1fffff, 1, 1'b1, 1'b0};
`else
    tv[1] = '{21'h0ffff0, 1, {9'h0, 9'h0, 9'h0, 9'h0ff}, {9'h0, 9'h0, 9'h0, 9'h0ff},
              1'b1, 21'h00fdf1, 1, 1'b1, 1'b0};
    tv[7] = '{21'h1fffff, 1, {9'h0, 9'h0, 9'h0, 9'h101}, {9'h0, 9'h0, 9'h0, 9'h001},
              1'b1, 21'h000000, 1, 1'b1, 1'b0};
`endif
    tv[2] = '{21'h000005, 1, {9'h0, 9'h0, 9'h0, 9'h105}, {9'h0, 9'h0, 9'h0, 9'h001},
              1'b1, 21'h000000, 1, 1'b0, 1'b0};
    tv[3] = '{21'h100000, 1, {9'h0, 9'h0, 9'h0, 9'h000}, {9'h0, 9'h0, 9'h0, 9'h005},
              1'b1, 21'h000000, 1, 1'b0, 1'b0};
    tv[4] = '{21'h00000a, 4, {9'h001, 9'h001, 9'h001, 9'h001}, {9'h001, 9'h001, 9'h001, 9'h001},
              1'b0, 21'h00000e, 4, 1'b0, 1'b1};
    tv[5] = '{21'h100003, 1, {9'h0, 9'h0, 9'h0, 9'h002}, {9'h0, 9'h0, 9'h0, 9'h003},
              1'b1, 21'h000003, 1, 1'b0, 1'b0};
    tv[6] = '{21'h000001, 2, {9'h0, 9'h0, 9'h103, 9'h101}, {9'h0, 9'h0, 9'h003, 9'h101},
              1'b1, 21'h100007, 2, 1'b0, 1'b0};
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_flags", 32'({out_ovf, out_err}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) run(tv[i], $sformatf("vec%0d", i), 0);
    hv = '{21'h000002, 1, {9'h0, 9'h0, 9'h0, 9'h002}, {9'h0, 9'h0, 9'h0, 9'h002},
           1'b1, 21'h000006, 1, 1'b0, 1'b0};
    run(hv, "hold", 3);
    hv = '{21'h000000, 1, {9'h0, 9'h0, 9'h0, 9'h001}, {9'h0, 9'h0, 9'h0, 9'h001},
           1'b1, 21'h000001, 1, 1'b0, 1'b0};
    run(hv, "b2b", 0);
    bias = 21'd100;
    in_x = 9'h001;
    in_w = 9'h001;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_count", 32'(out_count), 32'd0);
    chk("midrst_out_sum", 32'(out_sum), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    hv = '{21'h100007, 1, {9'h0, 9'h0, 9'h0, 9'h001}, {9'h0, 9'h0, 9'h0, 9'h002},
           1'b1, 21'h100005, 1, 1'b0, 1'b0};
    run(hv, "fresh", 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
